// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Holds the fetch FSM encoding and counter sizing helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between the instruction bus and DECODE.
// Synchronous clear drops every entry in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_C);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: pipelined Wishbone read master
// with credit-limited prefetch into a FIFO feeding DECODE.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_stall_i,
  output logic [ADDR_W-1:0] wb_addr_o,
  input  logic              wb_ack_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              dc_valid_o,
  input  logic              dc_ready_i,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic [DATA_W-1:0] dc_data_o,
  input  logic              dc_valid_i,
  input  logic [ADDR_W-1:0] dc_addr_i
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(DEPTH);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic              load;
  logic [ADDR_W-1:0] req_q;
  logic [ADDR_W-1:0] ack_q;
  logic [CNT_W-1:0]  outst_q;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    inflight;
  logic              stb;
  logic              cyc;
  logic              issue;
  logic              ack_ok;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [ENT_W-1:0]  head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dc_valid_i) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (dc_valid_i) begin
          state_d = FLUSH;
          load    = 1'b1;
        end
      end
      FLUSH: begin
        load    = dc_valid_i;
        state_d = dc_valid_i ? FLUSH : RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Words buffered plus words still on the bus never exceed DEPTH,
  // so an ack always finds room in the FIFO.
  assign inflight = {1'b0, fifo_cnt} + {1'b0, outst_q};
  assign stb      = (state_q == RUN) && (inflight < LIMIT);
  assign cyc      = stb || (outst_q != '0);
  assign issue    = stb && !wb_stall_i;
  assign ack_ok   = cyc && wb_ack_i;

  assign pop  = !empty && dc_ready_i && !load;
  assign push = ack_ok && !load && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= '0;
      ack_q   <= '0;
      outst_q <= '0;
    end else if (load) begin
      req_q   <= dc_addr_i;
      ack_q   <= dc_addr_i;
      outst_q <= '0;
    end else begin
      if (issue) begin
        req_q <= req_q + ADDR_W'(1);
      end
      if (ack_ok) begin
        ack_q <= ack_q + ADDR_W'(1);
      end
      unique case ({issue, ack_ok})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (load),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({ack_q, wb_data_i}),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (fifo_cnt)
  );

  assign wb_cyc_o   = cyc;
  assign wb_stb_o   = stb;
  assign wb_addr_o  = req_q;
  assign dc_valid_o = !empty;
  // Hide stale RAM contents when nothing is presented.
  assign {dc_addr_o, dc_data_o} = empty ? '0 : head;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized bench for fetch_prefetch with a queue-based
// reference of the bus slave, prefetch buffer and DECODE stream.
module tb_fetch_prefetch;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_stall_i = 1'b0;
  logic [AW-1:0] wb_addr_o;
  logic          wb_ack_i = 1'b0;
  logic [DW-1:0] wb_data_i = '0;
  logic          dc_valid_o;
  logic          dc_ready_i = 1'b0;
  logic [AW-1:0] dc_addr_o;
  logic [DW-1:0] dc_data_o;
  logic          dc_valid_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;

  fetch_prefetch #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_stall_i (wb_stall_i),
    .wb_addr_o  (wb_addr_o),
    .wb_ack_i   (wb_ack_i),
    .wb_data_i  (wb_data_i),
    .dc_valid_o (dc_valid_o),
    .dc_ready_i (dc_ready_i),
    .dc_addr_o  (dc_addr_o),
    .dc_data_o  (dc_data_o),
    .dc_valid_i (dc_valid_i),
    .dc_addr_i  (dc_addr_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef enum {M_IDLE, M_RUN, M_FLUSH} mode_t;
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  mode_t         mode = M_IDLE;
  req_t          pend[$];
  logic [31:0]   fq[$];
  logic [AW-1:0] exp_req = '0;
  int            now = 0;

  int            p_stall = 0;
  int            p_ready = 100;
  int            p_redir = 0;
  int            lat_max = 0;
  bit            f_redir = 0;
  bit            f_rst = 0;
  logic [AW-1:0] f_addr = '0;
  bit            redir_on_ack = 0;
  int            stall_left = 0;

  int            issued = 0;
  int            pops = 0;
  int            iss_0102 = 0;
  bit            seen_zero = 0;
  bit            fired = 0;

  bit            rst_chk = 0;
  bit            flush_chk = 0;
  bit            start_chk = 0;
  bit            hold_chk = 0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] hold_addr = '0;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic cycle();
    bit            exp_stb;
    bit            exp_cyc;
    bit            iss;
    bit            ackev;
    bit            pop;
    bit            redir;
    bit            rs;
    logic [AW-1:0] raddr;
    req_t          r;

    if (rst_chk) begin
      check("rst_cyc", wb_cyc_o, 0);
      check("rst_stb", wb_stb_o, 0);
      check("rst_wb_addr", wb_addr_o, 0);
      check("rst_valid", dc_valid_o, 0);
      check("rst_dc_addr", dc_addr_o, 0);
      check("rst_dc_data", dc_data_o, 0);
      rst_chk = 0;
    end
    if (flush_chk) begin
      check("flush_cyc", wb_cyc_o, 0);
      check("flush_valid", dc_valid_o, 0);
      flush_chk = 0;
    end
    if (start_chk) begin
      check("start_stb", wb_stb_o, 1);
      check("start_addr", wb_addr_o, start_addr);
      start_chk = 0;
    end
    if (hold_chk) begin
      check("hold_stb", wb_stb_o, 1);
      check("hold_addr", wb_addr_o, hold_addr);
      hold_chk = 0;
    end

    exp_stb = (mode == M_RUN) && (fq.size() + pend.size() < DEPTH);
    exp_cyc = exp_stb || (pend.size() != 0);
    check("dc_valid", dc_valid_o, fq.size() != 0);
    if (fq.size() != 0) check("dc_head", {dc_addr_o, dc_data_o}, fq[0]);
    check("stb", wb_stb_o, exp_stb);
    check("cyc", wb_cyc_o, exp_cyc);
    if (exp_stb) check("req_addr", wb_addr_o, exp_req);

    wb_stall_i = int'($urandom_range(99)) < p_stall;
    if (stall_left > 0 && wb_stb_o && wb_addr_o == 16'h0102) begin
      wb_stall_i = 1'b1;
      stall_left--;
    end
    if (pend.size() != 0 && pend[0].due <= now) begin
      wb_ack_i  = 1'b1;
      wb_data_i = word(pend[0].addr);
    end else if (!exp_cyc && $urandom_range(9) == 0) begin
      wb_ack_i  = 1'b1;
      wb_data_i = 16'($urandom);
    end else begin
      wb_ack_i  = 1'b0;
      wb_data_i = 16'($urandom);
    end
    dc_ready_i = int'($urandom_range(99)) < p_ready;

    raddr = 16'($urandom);
    redir = int'($urandom_range(999)) < p_redir;
    if (redir_on_ack && wb_ack_i && pend.size() >= 2) begin
      redir        = 1;
      raddr        = 16'h2000;
      fired        = 1;
      redir_on_ack = 0;
    end
    if (f_redir) begin
      redir   = 1;
      raddr   = f_addr;
      f_redir = 0;
    end
    dc_valid_i = redir;
    dc_addr_i  = raddr;
    rs         = f_rst;
    rst        = rs;
    f_rst      = 0;

    iss   = exp_stb && !wb_stall_i;
    ackev = exp_cyc && wb_ack_i;
    pop   = (fq.size() != 0) && dc_ready_i;

    if (pop) begin
      pops++;
      if (fq[0][31:16] == 16'h0000) seen_zero = 1;
    end
    hold_chk  = !rs && !redir && exp_stb && wb_stall_i;
    hold_addr = exp_req;

    if (rs) begin
      mode = M_IDLE;
      fq.delete();
      pend.delete();
      exp_req = '0;
      rst_chk = 1;
      flush_chk = 0;
      start_chk = 0;
    end else if (redir) begin
      start_addr = raddr;
      if (mode == M_IDLE) begin
        mode = M_RUN;
        start_chk = 1;
      end else begin
        mode = M_FLUSH;
        flush_chk = 1;
      end
      fq.delete();
      pend.delete();
      exp_req = raddr;
    end else begin
      if (mode == M_FLUSH) begin
        mode = M_RUN;
        start_chk = 1;
      end
      if (pop) void'(fq.pop_front());
      if (ackev && pend.size() != 0) begin
        fq.push_back({pend[0].addr, word(pend[0].addr)});
        void'(pend.pop_front());
      end
      if (iss) begin
        r.addr = exp_req;
        r.due  = now + 1 + int'($urandom_range(lat_max));
        pend.push_back(r);
        issued++;
        if (exp_req == 16'h0102) iss_0102++;
        exp_req = exp_req + 16'd1;
      end
    end

    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int p0;
    int i0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    rst_chk = 1;

    f_redir = 1;
    f_addr  = 16'h0100;
    run(5);
    p0 = pops;
    run(10);
    check("throughput", pops - p0, 10);

    p_ready = 0;
    f_redir = 1;
    f_addr  = 16'h0100;
    run(1);
    i0 = issued;
    run(11);
    check("credit_issued", issued - i0, DEPTH);
    check("head_hold", dc_addr_o, 16'h0100);
    p_ready = 100;
    run(10);

    f_redir    = 1;
    f_addr     = 16'h0100;
    stall_left = 3;
    iss_0102   = 0;
    run(15);
    check("stall_once", iss_0102, 1);
    check("stall_used", stall_left, 0);

    lat_max      = 2;
    fired        = 0;
    redir_on_ack = 1;
    for (int i = 0; i < 50 && !fired; i++) cycle();
    check("redir_fired", fired, 1);
    redir_on_ack = 0;
    run(10);
    lat_max = 0;

    f_redir   = 1;
    f_addr    = 16'hFFFE;
    seen_zero = 0;
    run(12);
    check("wrap", seen_zero, 1);

    run(3);
    f_rst   = 1;
    f_redir = 1;
    f_addr  = 16'h1234;
    run(1);
    i0 = issued;
    run(10);
    check("idle_no_req", issued - i0, 0);

    for (int k = 0; k < 8; k++) begin
      p_stall = int'($urandom_range(60));
      p_ready = 20 + int'($urandom_range(80));
      p_redir = int'($urandom_range(80));
      lat_max = int'($urandom_range(4));
      if (k == 4) f_rst = 1;
      f_redir = 1;
      f_addr  = 16'($urandom);
      run(400);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
